// File: rtl/tour_move_sched.sv
// Replays a stored knight's tour into cmd_proc as vertical/horizontal move commands,
// and owns the command interface while the tour runs (UART passes through when idle).
module tour_move_sched #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tour_go,
  output logic [IDX_W-1:0] move_addr,
  input  logic [7:0]       move,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic             clr_cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             tour_active
);

  typedef enum logic [2:0] {IDLE, LOAD, VERT, VWAIT, HORZ, HWAIT} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_MOVES - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       move_reg;
  logic             rd_vld;
  logic [15:0]      tcmd;
  logic             tcmd_rdy;

  // Leg command for the lowest set bit of a one-hot move; horz selects the x leg.
  function automatic logic [15:0] leg_cmd(input logic [7:0] m, input logic horz);
    logic [2:0] b;
    logic       neg;
    logic [2:0] mag;
    b = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) b = 3'(i);
    if (!horz) begin
      neg = (b >= 3'd3) && (b <= 3'd6);
      mag = (b == 3'd0 || b == 3'd1 || b == 3'd4 || b == 3'd5) ? 3'd2 : 3'd1;
      leg_cmd = {4'h4, neg ? 8'h7F : 8'h00, 1'b0, mag};
    end else begin
      neg = (b >= 3'd1) && (b <= 3'd4);
      mag = (b == 3'd2 || b == 3'd3 || b == 3'd6 || b == 3'd7) ? 3'd2 : 3'd1;
      leg_cmd = {4'h5, neg ? 8'h3F : 8'hBF, 1'b0, mag};
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      move_reg <= '0;
      rd_vld   <= 1'b0;
      tcmd     <= '0;
      tcmd_rdy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (tour_go) begin
          idx    <= '0;
          rd_vld <= 1'b0;
          state  <= LOAD;
        end
        // First LOAD cycle presents the address; the second sees the memory data.
        LOAD: if (!rd_vld) begin
          rd_vld <= 1'b1;
        end else begin
          rd_vld   <= 1'b0;
          move_reg <= move;
          if (move == 8'h00) begin
            state <= IDLE;
          end else begin
            tcmd     <= leg_cmd(move, 1'b0);
            tcmd_rdy <= 1'b1;
            state    <= VERT;
          end
        end
        VERT: if (clr_cmd_rdy) begin
          tcmd_rdy <= 1'b0;
          state    <= VWAIT;
        end
        VWAIT: if (send_resp) begin
          tcmd     <= leg_cmd(move_reg, 1'b1);
          tcmd_rdy <= 1'b1;
          state    <= HORZ;
        end
        HORZ: if (clr_cmd_rdy) begin
          tcmd_rdy <= 1'b0;
          state    <= HWAIT;
        end
        HWAIT: if (send_resp) begin
          if (idx == LAST) begin
            state <= IDLE;
          end else begin
            idx   <= idx + 1'b1;
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign move_addr   = idx;
  assign tour_active = (state != IDLE);

  // Ownership follows the registered state only, so a tour_go never glitches this cycle.
  assign cmd              = tour_active ? tcmd : cmd_UART;
  assign cmd_rdy          = tour_active ? tcmd_rdy : cmd_rdy_UART;
  assign clr_cmd_rdy_UART = tour_active ? 1'b0 : clr_cmd_rdy;

  assign resp = ((state == HWAIT && idx == LAST) ||
                 (state == LOAD && rd_vld && move == 8'h00)) ? 8'h5A : 8'hA5;

endmodule

// File: tb/tb_tour_move_sched.sv
// Directed bench for tour_move_sched: a leg-sequence scoreboard built from the tour
// memory plus per-cycle interface checks, and literal spot checks.
module tb_tour_move_sched;
  localparam int NM = 8;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tour_go = 1'b0;
  logic [IW-1:0] move_addr;
  logic [7:0]    move;
  logic [15:0]   cmd_UART = 16'h0;
  logic          cmd_rdy_UART = 1'b0;
  logic          clr_cmd_rdy_UART;
  logic [15:0]   cmd;
  logic          cmd_rdy;
  logic          clr_cmd_rdy = 1'b0;
  logic          send_resp = 1'b0;
  logic [7:0]    resp;
  logic          tour_active;

  tour_move_sched #(.NUM_MOVES(NM), .IDX_W(IW)) u_dut (
    .clk(clk), .rst_n(rst_n), .tour_go(tour_go), .move_addr(move_addr), .move(move),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .resp(resp), .tour_active(tour_active)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:31];
  always @(posedge clk) move <= mem[move_addr];

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] q[$];
  bit await_resp = 1'b0;
  bit chk_en = 1'b0;
  int total_legs;
  bit full_tour;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Knight displacement table, indexed by the one-hot bit position.
  int dx_t [8] = '{ 1, -1, -2, -2, -1,  1,  2,  2};
  int dy_t [8] = '{ 2,  2,  1, -1, -2, -2, -1,  1};

  function automatic logic [15:0] exp_leg(input logic [7:0] m, input bit horz);
    int b, d, a;
    b = 0;
    for (int i = 0; i < 8; i++) if (m[i]) begin b = i; break; end
    d = horz ? dx_t[b] : dy_t[b];
    a = (d < 0) ? -d : d;
    if (!horz) return {4'h4, (d > 0) ? 8'h00 : 8'h7F, 1'b0, 3'(a)};
    else       return {4'h5, (d < 0) ? 8'h3F : 8'hBF, 1'b0, 3'(a)};
  endfunction

  task automatic build_model();
    q.delete();
    for (int i = 0; i < NM; i++) begin
      if (mem[i] == 8'h00) break;
      q.push_back(exp_leg(mem[i], 1'b0));
      q.push_back(exp_leg(mem[i], 1'b1));
    end
    total_legs = q.size();
    full_tour  = (total_legs == 2 * NM);
  endtask

  // Per-cycle interface checks.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      if (!tour_active) begin
        chk("pass_cmd", cmd, cmd_UART);
        chk("pass_rdy", 16'(cmd_rdy), 16'(cmd_rdy_UART));
        chk("pass_clr", 16'(clr_cmd_rdy_UART), 16'(clr_cmd_rdy));
      end else begin
        chk("uart_blocked", 16'(clr_cmd_rdy_UART), 16'h0);
        if (cmd_rdy) begin
          chk("rdy_before_resp", 16'(await_resp), 16'h0);
          if (q.size() == 0) chk("extra_cmd_rdy", 16'(cmd_rdy), 16'h0);
          else begin
            chk("tour_cmd", cmd, q[0]);
            if (clr_cmd_rdy) begin
              void'(q.pop_front());
              await_resp = 1'b1;
            end
          end
        end
      end
      if (send_resp) await_resp = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_rdy();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_rdy) break;
    end
    if (!cmd_rdy) chk("timeout_cmd_rdy", 16'(cmd_rdy), 16'h1);
    tick();
  endtask

  task automatic do_leg(input int delay, input bit spurious, input bit stray_go,
                        input bit no_resp, input logic [7:0] exp_resp, input logic [15:0] lit);
    wait_rdy();
    if (lit != 16'h0) chk("leg_literal", cmd, lit);
    for (int d = 0; d < delay; d++) begin
      send_resp = spurious && (d == delay / 2);
      tick();
    end
    send_resp = 1'b0;
    if (spurious) begin
      chk("hold_rdy", 16'(cmd_rdy), 16'h1);
      chk("hold_active", 16'(tour_active), 16'h1);
    end
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    chk("rdy_dropped", 16'(cmd_rdy), 16'h0);
    tour_go = stray_go;
    tick();
    tour_go = 1'b0;
    tick();
    if (no_resp) return;
    chk("resp", 16'(resp), 16'(exp_resp));
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
  endtask

  task automatic start_tour();
    build_model();
    tour_go = 1'b1;
    tick();
    tour_go = 1'b0;
    chk("start_active", 16'(tour_active), 16'h1);
    chk("start_addr", 16'(move_addr), 16'h0);
  endtask

  task automatic finish_tour();
    if (full_tour) begin
      chk("end_active", 16'(tour_active), 16'h0);
    end else begin
      tick();
      chk("end_resp_zero_move", 16'(resp), 16'h5A);
      tick();
      chk("end_active", 16'(tour_active), 16'h0);
    end
    chk("end_resp_idle", 16'(resp), 16'hA5);
    chk("end_queue_empty", 16'(q.size()), 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;

    // Pin the model to hand-derived encodings.
    chk("model_b0_v", exp_leg(8'h01, 1'b0), 16'h4002);
    chk("model_b0_h", exp_leg(8'h01, 1'b1), 16'h5BF1);
    chk("model_b3_v", exp_leg(8'h08, 1'b0), 16'h47F1);
    chk("model_b3_h", exp_leg(8'h08, 1'b1), 16'h53F2);
    chk("model_lowest", exp_leg(8'h06, 1'b1), 16'h53F1);

    #12;
    chk("rst_active", 16'(tour_active), 16'h0);
    chk("rst_rdy", 16'(cmd_rdy), 16'h0);
    chk("rst_resp", 16'(resp), 16'hA5);
    chk("rst_addr", 16'(move_addr), 16'h0);
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;

    // UART pass-through while idle.
    cmd_UART = 16'h2000; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
    #1;
    chk("uart_cmd", cmd, 16'h2000);
    chk("uart_clr", 16'(clr_cmd_rdy_UART), 16'h1);
    tick();
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
    tick();

    // Single move, terminated by an empty slot.
    mem[0] = 8'h01;
    start_tour();
    do_leg(0, 0, 0, 0, 8'hA5, 16'h4002);
    do_leg(0, 0, 0, 0, 8'hA5, 16'h5BF1);
    finish_tour();

    // All eight directions with UART held pending; tour_go lands with a pass-through clr.
    for (int i = 0; i < NM; i++) mem[i] = 8'h01 << i;
    cmd_rdy_UART = 1'b1;
    build_model();
    tour_go = 1'b1; clr_cmd_rdy = 1'b1;
    #1;
    chk("go_same_cycle_clr", 16'(clr_cmd_rdy_UART), 16'h1);
    tick();
    tour_go = 1'b0; clr_cmd_rdy = 1'b0;
    chk("go_active", 16'(tour_active), 16'h1);
    for (int l = 0; l < total_legs; l++)
      do_leg(l % 3, 0, (l == 5), 0, (l == total_legs - 1) ? 8'h5A : 8'hA5,
             (l == 6) ? 16'h47F1 : 16'h0);
    finish_tour();
    clr_cmd_rdy = 1'b1;
    #1;
    chk("uart_after_tour", 16'(clr_cmd_rdy_UART), 16'h1);
    tick();
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
    tick();

    // Handshake hold with spurious send_resp, then reset in VWAIT of move 5.
    start_tour();
    do_leg(20, 1, 0, 0, 8'hA5, 16'h0);
    for (int l = 1; l < 10; l++) do_leg(0, 0, 0, 0, 8'hA5, 16'h0);
    do_leg(0, 0, 0, 1, 8'hA5, 16'h0);
    chk("pre_rst_addr", 16'(move_addr), 16'h5);
    rst_n = 1'b0;
    #1;
    chk("midrst_active", 16'(tour_active), 16'h0);
    chk("midrst_rdy", 16'(cmd_rdy), 16'h0);
    chk("midrst_addr", 16'(move_addr), 16'h0);
    q.delete(); await_resp = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Restart with multi-bit moves: the lowest set bit decides.
    for (int i = 0; i < NM; i++) mem[i] = 8'hFF << i;
    start_tour();
    for (int l = 0; l < total_legs; l++)
      do_leg(1, 0, 0, 0, (l == total_legs - 1) ? 8'h5A : 8'hA5, (l == 1) ? 16'h5BF1 : 16'h0);
    finish_tour();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
